// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch / IF-ID pipeline slice.
//   PC_W       : program-counter width
//   NOP_INSTR  : encoding squashed into IF/ID on a redirect
//   fetch_state_e : fetch-stage state encoding
package pipeline_pkg;

    localparam int PC_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the fetch-stage performance counters.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   inc   : add one this cycle (ignored once the counter is at all-ones)
//   count : current value
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage plus the IF/ID pipeline register.
// Holds the PC, captures the fetched instruction one cycle after its address
// is presented, handles hazard stalls and ID-resolved redirects, and runs a
// sticky watchdog on long stall runs.
//
// Optional build macro: IF_ID_PERF_CNT_EN enables the StallCount/FlushCount
// performance counters; without it both ports are tied to zero.
//
// Ports:
//   Clk, Reset          : clock and synchronous active-high reset
//   FlushSignal         : hazard hold (PC and IF/ID held, bubble into ID/EX)
//   BranchTaken/Target  : redirect resolved in ID
//   Instr_IF            : instruction memory data for PC_IF
//   PC_IF               : fetch address
//   IF_ID_Instr/PCPlus4 : IF/ID register contents
//   IF_ID_Valid         : IF/ID holds a real instruction
//   BubbleSel           : select nop controls at the ID/EX mux
//   StallTimeout        : sticky watchdog flag
//   StallCount/FlushCount : performance counters
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal fetch, one instruction per cycle
// STALL    | hazard hold in progress, stall-run watchdog counting
// REDIRECT | first cycle after a taken branch; ID holds a squashed nop,
//          | so any BranchTaken seen now is stale and ignored
module if_id_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STALL_LIMIT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        FlushSignal,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] Instr_IF,
    output logic [31:0] PC_IF,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        BubbleSel,
    output logic        StallTimeout,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    import pipeline_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pcp4_q, pcp4_d;
    logic            valid_q, valid_d;
    logic [15:0]     stall_run_q, stall_run_d;
    logic            timeout_q, timeout_d;

    logic [PC_W-1:0] pc_plus4;
    logic            branch_accept;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;
        stall_run_d = '0;
        timeout_d   = timeout_q;

        // Wraps naturally at 2^32.
        pc_plus4      = pc_q + PC_W'(4);
        branch_accept = BranchTaken && (state_q != ST_REDIRECT);

        if (branch_accept) begin
            pc_d    = BranchTarget;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = ST_REDIRECT;
        end else if (FlushSignal) begin
            state_d = ST_STALL;
        end else begin
            pc_d    = pc_plus4;
            instr_d = Instr_IF;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
            state_d = ST_RUN;
        end

        // Run length counts the cycles the state register will have spent in
        // STALL, including the one being entered; leaving STALL clears it.
        if (state_d == ST_STALL) begin
            stall_run_d = (stall_run_q == 16'hFFFF) ? stall_run_q : stall_run_q + 16'd1;
        end

        if (stall_run_d >= 16'(STALL_LIMIT)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            pcp4_q      <= '0;
            valid_q     <= 1'b0;
            stall_run_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
            stall_run_q <= stall_run_d;
            timeout_q   <= timeout_d;
        end
    end

    assign PC_IF         = pc_q;
    assign IF_ID_Instr   = instr_q;
    assign IF_ID_PCPlus4 = pcp4_q;
    assign IF_ID_Valid   = valid_q;
    assign StallTimeout  = timeout_q;

    // Combinational so the ID/EX mux sees the hazard in the same cycle.
    assign BubbleSel = FlushSignal | ~valid_q;

`ifdef IF_ID_PERF_CNT_EN
    logic stall_inc;

    assign stall_inc = FlushSignal && !branch_accept;

    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (stall_inc),
        .count (StallCount)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (branch_accept),
        .count (FlushCount)
    );
`else
    assign StallCount = 16'h0000;
    assign FlushCount = 16'h0000;
`endif

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address after reset.
REQ-002 SHALL have parameter STALL_LIMIT, default 15, meaning the consecutive-stall cycle count at which the timeout flag sets.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous and active-high.
REQ-005 SHALL have port FlushSignal, input, 1, from the hazard unit; 1 = hold PC and IF/ID and insert a nop into ID/EX.
REQ-006 SHALL have port BranchTaken, input, 1, taken branch or jump resolved in ID.
REQ-007 SHALL have port BranchTarget, input, 32, redirect address.
REQ-008 SHALL have port Instr_IF, input, 32, combinational instruction-memory data for PC_IF.
REQ-009 SHALL have port PC_IF, output, 32, fetch address.
REQ-010 SHALL have port IF_ID_Instr, output, 32, instruction presented to ID.
REQ-011 SHALL have port IF_ID_PCPlus4, output, 32, PC+4 of IF_ID_Instr.
REQ-012 SHALL have port IF_ID_Valid, output, 1, IF_ID_Instr is a real instruction.
REQ-013 SHALL have port BubbleSel, output, 1, selects nop controls at the ID/EX mux.
REQ-014 SHALL have port StallTimeout, output, 1, sticky watchdog error flag.
REQ-015 SHALL have ports StallCount and FlushCount, output, 16 each, performance counters.

Function
REQ-016 SHALL implement states RUN, STALL and REDIRECT.
REQ-017 SHALL treat BranchTaken as highest priority in RUN and STALL: PC_IF<=BranchTarget; IF_ID_Instr<=32'h0 (nop); IF_ID_Valid<=0; next state REDIRECT.
REQ-018 SHALL, in RUN or STALL with FlushSignal=1 and no branch, hold PC_IF, IF_ID_Instr, IF_ID_PCPlus4 and IF_ID_Valid; next state STALL.
REQ-019 SHALL, in RUN with FlushSignal=0 and no branch, set PC_IF<=PC_IF+4, IF_ID_Instr<=Instr_IF, IF_ID_PCPlus4<=PC_IF+4 and IF_ID_Valid<=1.
REQ-020 SHALL, in STALL with FlushSignal=0, advance exactly as in RUN; next state RUN.
REQ-021 SHALL, in REDIRECT, ignore BranchTaken (ID holds a squashed nop), fetch normally subject to FlushSignal, and leave after exactly one cycle to RUN, or to STALL if FlushSignal=1.
REQ-022 SHALL drive BubbleSel combinationally as FlushSignal OR NOT IF_ID_Valid, with zero-cycle latency.
REQ-023 SHALL compute PC arithmetic modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-024 SHALL count consecutive cycles spent in STALL, clear the count on leaving STALL, and set StallTimeout when the count reaches STALL_LIMIT; StallTimeout stays set until Reset.
REQ-025 SHALL keep the fetch latency at one cycle from the PC_IF value to IF_ID_Instr.

Reset
REQ-026 SHALL, on Reset=1 at a clock edge, set PC_IF=RESET_PC, IF_ID_Instr=0, IF_ID_PCPlus4=0, IF_ID_Valid=0, state RUN, StallTimeout=0, StallCount=0, FlushCount=0 and the stall-run count to 0.
REQ-027 SHALL give Reset priority over FlushSignal and BranchTaken, including when asserted mid-stall or in REDIRECT.

Configuration
REQ-028 SHALL, with macro IF_ID_PERF_CNT_EN defined, increment StallCount each cycle in which FlushSignal=1 and no branch is accepted.
REQ-029 SHALL, with IF_ID_PERF_CNT_EN defined, increment FlushCount each cycle a branch is accepted; both counters saturate at 16'hFFFF.
REQ-030 SHALL, without IF_ID_PERF_CNT_EN, keep both count ports present and tie them to 16'h0000, with no counter logic.

Structure
REQ-031 SHALL place NOP_INSTR (32'h0), the state encoding and the PC width constant in shared package pipeline_pkg.
REQ-032 SHALL implement the 16-bit saturating counter as sub-module sat_counter, instantiated twice under IF_ID_PERF_CNT_EN.

Verification
REQ-033 SHALL cover: Reset, then 3 cycles with no hazards and RESET_PC=0 -> PC_IF 0,4,8,C and IF_ID_PCPlus4 4,8,C.
REQ-034 SHALL cover: FlushSignal=1 for 2 cycles at PC_IF=8 -> PC_IF and IF_ID_Instr held, BubbleSel=1 both cycles; StallCount=2 with the macro defined.
REQ-035 SHALL cover: BranchTaken=1 and FlushSignal=1 together, BranchTarget=32'h40 -> next PC_IF=40, IF_ID_Valid=0, BubbleSel=1, FlushCount=1.
REQ-036 SHALL cover: BranchTaken=1 during REDIRECT -> ignored, PC_IF advances 44 to 48.
REQ-037 SHALL cover: FlushSignal held for 15 cycles -> StallTimeout=1, still 1 after release, cleared only by Reset.
REQ-038 SHALL cover: PC_IF=FFFF_FFFC with no hazard -> PC_IF=0; and Reset mid-stall -> all outputs at reset values next edge.
